// File: rtl/riscv_pkg.sv
// Shared core definitions: datapath width, reset vector, NOP encoding and
// the fetch sequencer state encoding.
package riscv_pkg;

    localparam int              XLEN             = 32;
    localparam logic [31:0]     RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0]     NOP_INSTR        = 32'h0000_0013;

    typedef enum logic {
        FS_RUN   = 1'b0,
        FS_FAULT = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Fetch-side bus bundle: instruction memory read port plus the decode handshake.
// master = fetch unit, slave = memory/decode side.
interface instr_fetch_unit_if #(
    parameter int XLEN = 32
);
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic [31:0]     imem_rdata;
    logic            if_valid;
    logic            if_ready;
    logic [31:0]     if_instr;
    logic [XLEN-1:0] if_pc;

    modport master (
        output imem_req, imem_addr, if_valid, if_instr, if_pc,
        input  imem_rdata, if_ready
    );

    modport slave (
        input  imem_req, imem_addr, if_valid, if_instr, if_pc,
        output imem_rdata, if_ready
    );
endinterface

// File: rtl/instr_fetch_unit_queue.sv
// Two-entry FIFO of {pc, instr} between the memory return path and decode.
// Flush wins over push/pop; storage is unreset, only pointers/count are.
module fetch_queue
    import riscv_pkg::*;
#(
    parameter int PC_W = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push,
    input  logic            pop,
    input  logic            flush,
    input  logic [PC_W-1:0] push_pc,
    input  logic [31:0]     push_instr,
    output logic [PC_W-1:0] head_pc,
    output logic [31:0]     head_instr,
    output logic [1:0]      count,
    output logic            empty,
    output logic            full
);
    logic [PC_W-1:0] pc_mem    [2];
    logic [31:0]     instr_mem [2];
    logic            rd_ptr;
    logic            wr_ptr;
    logic            do_pop;
    logic            do_push;

    assign empty      = (count == 2'd0);
    assign full       = (count == 2'd2);
    assign do_pop     = pop & ~empty;
    // A full queue may still accept a push when its head leaves in the same cycle.
    assign do_push    = push & (~full | do_pop);
    assign head_pc    = pc_mem[rd_ptr];
    assign head_instr = instr_mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else if (flush) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) wr_ptr <= ~wr_ptr;
            if (do_pop)  rd_ptr <= ~rd_ptr;
            case ({do_push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            pc_mem[wr_ptr]    <= push_pc;
            instr_mem[wr_ptr] <= push_instr;
        end
    end
endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch sequencer: PC, credit-limited memory reads, epoch-tagged
// returns into a 2-entry queue, redirect handling and fault halt.
module instr_fetch_unit #(
    parameter int              XLEN      = riscv_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC  = riscv_pkg::RESET_PC_DEFAULT,
    parameter int              MEM_WORDS = 1024
) (
    input  logic                clk,
    input  logic                rst,
    instr_fetch_unit_if.master  bus,
    input  logic                redirect_valid,
    input  logic [XLEN-1:0]     redirect_pc,
    output logic                fetch_fault
);
    import riscv_pkg::*;

    localparam logic [XLEN:0] PC_LIMIT = (XLEN+1)'(MEM_WORDS * 4);

    function automatic logic pc_legal(input logic [XLEN-1:0] addr);
        return (addr[1:0] == 2'b00) && ({1'b0, addr} < PC_LIMIT);
    endfunction

    fetch_state_t    state_q;
    fetch_state_t    state_d;
    logic [XLEN-1:0] pc_q;
    logic            epoch_q;
    logic            issue;
    logic            inflight_p1;
    logic            tag_epoch_p1;
    logic [XLEN-1:0] tag_pc_p1;
    logic            q_push;
    logic            q_pop;
    logic            q_empty;
    logic            q_full;
    logic [1:0]      q_count;
    logic [XLEN-1:0] q_head_pc;
    logic [31:0]     q_head_instr;
    logic [2:0]      used;
    logic            credit_ok;

    // A head leaving this cycle frees its slot, which keeps one read per cycle going.
    assign q_pop     = ~q_empty & bus.if_ready;
    assign used      = {1'b0, q_count} + {2'b00, inflight_p1} - {2'b00, q_pop};
    assign credit_ok = (used < 3'd2);

    // Reads issued before a redirect come back under the old epoch, or in the
    // redirect cycle itself; either way they are discarded.
    assign q_push    = inflight_p1 & (tag_epoch_p1 == epoch_q) & ~redirect_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= FS_RUN;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            FS_RUN:   if (!redirect_valid && !pc_legal(pc_q))         state_d = FS_FAULT;
            FS_FAULT: if (redirect_valid && pc_legal(redirect_pc))   state_d = FS_RUN;
        endcase
    end

    always_comb begin
        issue       = 1'b0;
        fetch_fault = (state_q == FS_FAULT);
        if (!rst && state_q == FS_RUN && !redirect_valid && pc_legal(pc_q) && credit_ok)
            issue = 1'b1;
    end

    // p0 -> p1: read issued, tag captured for the returning word
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q         <= RESET_PC;
            epoch_q      <= 1'b0;
            inflight_p1  <= 1'b0;
            tag_epoch_p1 <= 1'b0;
        end else begin
            if (redirect_valid) begin
                pc_q    <= redirect_pc;
                epoch_q <= ~epoch_q;
            end else if (issue) begin
                pc_q    <= pc_q + XLEN'(4);
            end
            inflight_p1  <= issue;
            tag_epoch_p1 <= epoch_q;
        end
    end

    always_ff @(posedge clk) begin
        if (issue) tag_pc_p1 <= pc_q;
    end

    fetch_queue #(.PC_W(XLEN)) u_queue (
        .clk        (clk),
        .rst        (rst),
        .push       (q_push),
        .pop        (q_pop),
        .flush      (redirect_valid),
        .push_pc    (tag_pc_p1),
        .push_instr (bus.imem_rdata),
        .head_pc    (q_head_pc),
        .head_instr (q_head_instr),
        .count      (q_count),
        .empty      (q_empty),
        .full       (q_full)
    );

    assign bus.imem_req  = issue;
    assign bus.imem_addr = pc_q;
    assign bus.if_valid  = ~q_empty;
    assign bus.if_pc     = q_empty ? '0 : q_head_pc;
    assign bus.if_instr  = q_empty ? '0 : q_head_instr;

    logic unused_ok;
    assign unused_ok = q_full;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: table of per-cycle expectations for the
// stall scenario plus hand-written redirect, fault, top-of-memory and reset sequences.
module tb_instr_fetch_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        fetch_fault;
    int          n_checks = 0;
    int          n_fail   = 0;

    instr_fetch_unit_if #(.XLEN(32)) bus ();

    instr_fetch_unit #(.XLEN(32), .RESET_PC(32'h0), .MEM_WORDS(1024)) dut (
        .clk            (clk),
        .rst            (rst),
        .bus            (bus),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .fetch_fault    (fetch_fault)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word_at(input logic [31:0] pc);
        return 32'hA500_0000 + (pc >> 2);
    endfunction

    logic [31:0] mem [1024];
    always @(posedge clk) begin
        if (bus.imem_req) bus.imem_rdata <= mem[bus.imem_addr[11:2]];
    end

    typedef struct {
        logic        ready;
        logic        exp_valid;
        logic [31:0] exp_pc;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_fault;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic v, input logic [31:0] pc,
                                input logic q, input logic [31:0] a);
        vec_t t;
        t.ready = r; t.exp_valid = v; t.exp_pc = pc;
        t.exp_req = q; t.exp_addr = a; t.exp_fault = 1'b0;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [31:0] pc,
                           input logic q, input logic [31:0] a, input logic f);
        chk({tag, ".if_valid"}, {31'b0, bus.if_valid}, {31'b0, v});
        if (v) begin
            chk({tag, ".if_pc"},    bus.if_pc,    pc);
            chk({tag, ".if_instr"}, bus.if_instr, word_at(pc));
        end
        chk({tag, ".imem_req"}, {31'b0, bus.imem_req}, {31'b0, q});
        if (q) chk({tag, ".imem_addr"}, bus.imem_addr, a);
        chk({tag, ".fetch_fault"}, {31'b0, fetch_fault}, {31'b0, f});
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, ".if_valid"},    {31'b0, bus.if_valid},  32'h0);
        chk({tag, ".imem_req"},    {31'b0, bus.imem_req},  32'h0);
        chk({tag, ".imem_addr"},   bus.imem_addr,          32'h0);
        chk({tag, ".if_pc"},       bus.if_pc,              32'h0);
        chk({tag, ".if_instr"},    bus.if_instr,           32'h0);
        chk({tag, ".fetch_fault"}, {31'b0, fetch_fault},   32'h0);
    endtask

    // Returns inside cycle 0 after reset release (just past a falling edge).
    task automatic start(input logic rdy);
        rst = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = 32'h0;
        bus.if_ready = rdy;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    task automatic step(input logic rdy, input logic rv, input logic [31:0] rpc);
        @(negedge clk);
        bus.if_ready = rdy;
        redirect_valid = rv;
        redirect_pc = rpc;
        #1;
    endtask

    vec_t tbl [11];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = word_at(32'(i) << 2);

        // Stall: ready drops on the first valid cycle for 5 cycles, then recovers.
        tbl[0]  = mk(1, 0, 32'h00, 1, 32'h00);
        tbl[1]  = mk(1, 0, 32'h00, 1, 32'h04);
        tbl[2]  = mk(0, 1, 32'h00, 0, 32'h00);
        tbl[3]  = mk(0, 1, 32'h00, 0, 32'h00);
        tbl[4]  = mk(0, 1, 32'h00, 0, 32'h00);
        tbl[5]  = mk(0, 1, 32'h00, 0, 32'h00);
        tbl[6]  = mk(0, 1, 32'h00, 0, 32'h00);
        tbl[7]  = mk(1, 1, 32'h00, 1, 32'h08);
        tbl[8]  = mk(1, 1, 32'h04, 1, 32'h0C);
        tbl[9]  = mk(1, 1, 32'h08, 1, 32'h10);
        tbl[10] = mk(1, 1, 32'h0C, 1, 32'h14);

        bus.if_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk_reset("reset");

        start(1'b1);
        for (int i = 0; i < 11; i++) begin
            if (i > 0) @(negedge clk);
            bus.if_ready = tbl[i].ready;
            redirect_valid = 1'b0;
            #1;
            chk_out($sformatf("stall_c%0d", i), tbl[i].exp_valid, tbl[i].exp_pc,
                    tbl[i].exp_req, tbl[i].exp_addr, tbl[i].exp_fault);
        end

        // Redirect to 0x40 while the read of 0x08 is in flight.
        start(1'b1);
        chk_out("redir_c0", 0, 32'h0, 1, 32'h00, 0);
        step(1, 0, 32'h0);
        step(1, 0, 32'h0);
        chk_out("redir_c2", 1, 32'h00, 1, 32'h08, 0);
        step(1, 1, 32'h40);
        chk_out("redir_c3", 1, 32'h04, 0, 32'h0, 0);
        step(1, 0, 32'h0);
        chk_out("redir_c4", 0, 32'h0, 1, 32'h40, 0);
        step(1, 0, 32'h0);
        chk_out("redir_c5", 0, 32'h0, 1, 32'h44, 0);
        step(1, 0, 32'h0);
        chk_out("redir_c6", 1, 32'h40, 1, 32'h48, 0);

        // Misaligned redirect faults; illegal redirect keeps fault; legal one clears it.
        start(1'b1);
        step(1, 0, 32'h0);
        step(1, 1, 32'h42);
        chk_out("flt_c2", 1, 32'h00, 0, 32'h0, 0);
        step(1, 0, 32'h0);
        chk_out("flt_c3", 0, 32'h0, 0, 32'h0, 0);
        step(1, 0, 32'h0);
        chk_out("flt_c4", 0, 32'h0, 0, 32'h0, 1);
        step(1, 1, 32'h0001_0000);
        chk_out("flt_c5", 0, 32'h0, 0, 32'h0, 1);
        step(1, 0, 32'h0);
        chk_out("flt_c6", 0, 32'h0, 0, 32'h0, 1);
        step(1, 1, 32'h10);
        chk_out("flt_c7", 0, 32'h0, 0, 32'h0, 1);
        step(1, 0, 32'h0);
        chk_out("flt_c8", 0, 32'h0, 1, 32'h10, 0);
        step(1, 0, 32'h0);
        chk_out("flt_c9", 0, 32'h0, 1, 32'h14, 0);
        step(1, 0, 32'h0);
        chk_out("flt_c10", 1, 32'h10, 1, 32'h18, 0);

        // Run off the top of memory: 0xFFC is delivered, then the unit faults.
        start(1'b1);
        redirect_valid = 1'b1;
        redirect_pc = 32'hFF0;
        #1;
        chk_out("top_c0", 0, 32'h0, 0, 32'h0, 0);
        step(1, 0, 32'h0);
        chk_out("top_c1", 0, 32'h0, 1, 32'hFF0, 0);
        step(1, 0, 32'h0);
        chk_out("top_c2", 0, 32'h0, 1, 32'hFF4, 0);
        step(1, 0, 32'h0);
        chk_out("top_c3", 1, 32'hFF0, 1, 32'hFF8, 0);
        step(1, 0, 32'h0);
        chk_out("top_c4", 1, 32'hFF4, 1, 32'hFFC, 0);
        step(1, 0, 32'h0);
        chk_out("top_c5", 1, 32'hFF8, 0, 32'h0, 0);
        step(1, 0, 32'h0);
        chk_out("top_c6", 1, 32'hFFC, 0, 32'h0, 1);
        step(1, 0, 32'h0);
        chk_out("top_c7", 0, 32'h0, 0, 32'h0, 1);

        // Asynchronous reset with the queue full, then restart from RESET_PC.
        start(1'b1);
        step(1, 0, 32'h0);
        step(0, 0, 32'h0);
        step(0, 0, 32'h0);
        step(0, 0, 32'h0);
        chk_out("midrst_full", 1, 32'h00, 0, 32'h0, 0);
        rst = 1'b1;
        #1;
        chk_reset("midrst");
        @(negedge clk);
        bus.if_ready = 1'b1;
        rst = 1'b0;
        #1;
        chk_out("restart_c0", 0, 32'h0, 1, 32'h00, 0);
        step(1, 0, 32'h0);
        chk_out("restart_c1", 0, 32'h0, 1, 32'h04, 0);
        step(1, 0, 32'h0);
        chk_out("restart_c2", 1, 32'h00, 1, 32'h08, 0);
        step(1, 0, 32'h0);
        chk_out("restart_c3", 1, 32'h04, 1, 32'h0C, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
